// File: rtl/inst_rom_pipe_pkg.sv
// inst_rom_pipe_pkg: shared defaults, types and ROM image for the pipelined instruction ROM
package inst_rom_pipe_pkg;
    localparam int INST_W_FIXED = 64;
    localparam int INST_ADDR_W_DEFAULT = 32;
    localparam int INST_MEM_DEPTH_DEFAULT = 1024;
    localparam int INST_LATENCY_DEFAULT = 2;
    localparam int FETCH_FIFO_DEPTH_DEFAULT = 4;
    localparam logic CHIP_ENABLE = 1'b1;

    typedef logic [INST_W_FIXED-1:0] inst_t;

    localparam inst_t ZERO_DOUBLE_WORD = '0;

    // Boot image: every word encodes its own index so a wrong fetch is always visible.
    function automatic inst_t rom_word(input logic [31:0] idx);
        return {idx ^ 32'h5A5A_0000, ~idx};
    endfunction

    function automatic logic addr_fault(input logic [63:0] addr, input int unsigned depth);
        return (addr[2:0] != 3'b000) || ((addr >> 3) >= 64'(depth));
    endfunction
endpackage

// File: rtl/inst_rom_pipe_if.sv
// inst_rom_pipe_if: fetch request/response bus between the IF-stage PC logic and the instruction ROM
interface inst_rom_pipe_if
    import inst_rom_pipe_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W_DEFAULT,
    parameter int INST_W = INST_W_FIXED
);
    logic              ce;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [INST_W-1:0] rsp_inst;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_fault;

    modport master (
        output ce, req_valid, req_addr, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_fault
    );

    modport slave (
        input  ce, req_valid, req_addr, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_fault
    );
endinterface

// File: rtl/fetch_rsp_fifo.sv
// fetch_rsp_fifo: in-order response buffer; flush empties it but a push in the same cycle still lands
module fetch_rsp_fifo #(
    parameter int W     = 97,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [AW-1:0] wr_idx;
    logic [W-1:0]  mem_q [DEPTH];

    always_comb begin
        wr_idx = bus_flush_idx(flush, wr_q[AW-1:0]);
        wr_d   = flush ? (AW+1)'(push) : wr_q + (AW+1)'(push);
        rd_d   = flush ? '0 : rd_q + (AW+1)'(pop);
        count  = wr_q - rd_q;
        full   = count == (AW+1)'(DEPTH);
        empty  = count == '0;
        dout   = mem_q[rd_q[AW-1:0]];
    end

    function automatic logic [AW-1:0] bus_flush_idx(input logic f, input logic [AW-1:0] idx);
        return f ? '0 : idx;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_idx] <= din;
    end
endmodule

// File: rtl/inst_rom_pipe.sv
// inst_rom_pipe: instruction ROM with credit-gated fetch port, LATENCY-deep read pipe and response FIFO
module inst_rom_pipe
    import inst_rom_pipe_pkg::*;
#(
    parameter int INST_W     = INST_W_FIXED,
    parameter int ADDR_W     = INST_ADDR_W_DEFAULT,
    parameter int DEPTH      = INST_MEM_DEPTH_DEFAULT,
    parameter int LATENCY    = INST_LATENCY_DEFAULT,
    parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH_DEFAULT
) (
    input logic            clk,
    input logic            rst,
    inst_rom_pipe_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int W     = ADDR_W + 1 + INST_W;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic [INST_W-1:0] rom [DEPTH];
    logic              accept, pop, push, s_flt, full, empty;
    logic [IDX_W-1:0]  s_idx;
    logic [INST_W-1:0] s_inst;
    logic [W-1:0]      s_dat, push_dat, head;
    logic [CW-1:0]     credit_q, credit_d, count;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = INST_W'(rom_word(32'(i)));
    end

    // Faulting fetches never touch the array, so out-of-range indices cannot alias real words.
    always_comb begin
        accept   = bus.req_valid & bus.req_ready;
        pop      = bus.rsp_valid & bus.rsp_ready;
        s_flt    = addr_fault(64'(bus.req_addr), DEPTH);
        s_idx    = bus.req_addr[IDX_W+2:3];
        s_inst   = s_flt ? ZERO_DOUBLE_WORD : rom[s_idx];
        s_dat    = {bus.req_addr, s_flt, s_inst};
        credit_d = bus.flush ? CW'(accept) : credit_q + CW'(accept) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) credit_q <= '0;
        else      credit_q <= credit_d;
    end

    if (LATENCY == 1) begin : g_direct
        assign push     = accept;
        assign push_dat = s_dat;
    end else begin : g_pipe
        localparam int P = LATENCY - 1;
        logic [P-1:0] vld_q, vld_d;
        logic [W-1:0] dat_q [P];
        logic [W-1:0] dat_d [P];
        // Stage 0 always takes the accepted request: in a flush cycle it is the redirect target.
        always_comb begin
            vld_d    = P'({vld_q & {P{~bus.flush}}, accept});
            dat_d[0] = s_dat;
            for (int k = 1; k < P; k++) dat_d[k] = dat_q[k-1];
        end
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q <= '0;
                dat_q <= '{default: '0};
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end
        assign push     = vld_q[P-1] & ~bus.flush;
        assign push_dat = dat_q[P-1];
    end

    fetch_rsp_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.flush),
        .push  (push),
        .din   (push_dat),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.req_ready = rst & (bus.ce == CHIP_ENABLE) & (credit_q < CW'(FIFO_DEPTH));
    assign bus.rsp_valid = ~empty;
    assign {bus.rsp_addr, bus.rsp_fault, bus.rsp_inst} = empty ? W'(0) : head;

    assert property (@(posedge clk) disable iff (!rst) !(push && full && !bus.flush));
    assert property (@(posedge clk) disable iff (!rst) (credit_q >= count) && (credit_q <= CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_inst_rom_pipe.sv
// tb_inst_rom_pipe: directed vector table plus hand-written backpressure, flush, ce and reset sequences
module tb_inst_rom_pipe;
    localparam logic [63:0] M0    = 64'h5A5A0000_FFFFFFFF;
    localparam logic [63:0] M1    = 64'h5A5A0001_FFFFFFFE;
    localparam logic [63:0] M2    = 64'h5A5A0002_FFFFFFFD;
    localparam logic [63:0] M3    = 64'h5A5A0003_FFFFFFFC;
    localparam logic [63:0] M4    = 64'h5A5A0004_FFFFFFFB;
    localparam logic [63:0] M8    = 64'h5A5A0008_FFFFFFF7;
    localparam logic [63:0] M1023 = 64'h5A5A03FF_FFFFFC00;

    typedef struct {
        logic        rv;
        logic [31:0] addr;
        logic        exp_rdy;
        logic        exp_vld;
        logic [31:0] exp_addr;
        logic        exp_flt;
        logic [63:0] exp_inst;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t v [11];

    always #5 clk = ~clk;

    inst_rom_pipe_if #(.ADDR_W(32), .INST_W(64)) bus ();

    inst_rom_pipe #(
        .INST_W(64), .ADDR_W(32), .DEPTH(1024), .LATENCY(2), .FIFO_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] a, input logic [63:0] inst, input logic flt);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                check({name, "_addr"}, 64'(bus.rsp_addr), 64'(a));
                check({name, "_inst"}, bus.rsp_inst, inst);
                check({name, "_fault"}, 64'(bus.rsp_fault), 64'(flt));
                tick();
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: rsp_valid never rose within 20 cycles", name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   extra;
        logic acc;
        logic [31:0] addrs [6];
        addrs = '{32'h0, 32'h8, 32'h10, 32'h18, 32'h20, 32'h28};

        v[0]  = '{1'b1, 32'h0000, 1'b1, 1'b0, 32'h0,    1'b0, 64'h0};
        v[1]  = '{1'b1, 32'h0008, 1'b1, 1'b0, 32'h0,    1'b0, 64'h0};
        v[2]  = '{1'b1, 32'h0010, 1'b1, 1'b1, 32'h0,    1'b0, M0};
        v[3]  = '{1'b1, 32'h000C, 1'b1, 1'b1, 32'h8,    1'b0, M1};
        v[4]  = '{1'b1, 32'h2000, 1'b1, 1'b1, 32'h10,   1'b0, M2};
        v[5]  = '{1'b1, 32'h0018, 1'b1, 1'b1, 32'hC,    1'b1, 64'h0};
        v[6]  = '{1'b1, 32'h1FF8, 1'b1, 1'b1, 32'h2000, 1'b1, 64'h0};
        v[7]  = '{1'b1, 32'h0007, 1'b1, 1'b1, 32'h18,   1'b0, M3};
        v[8]  = '{1'b0, 32'h0000, 1'b1, 1'b1, 32'h1FF8, 1'b0, M1023};
        v[9]  = '{1'b0, 32'h0000, 1'b1, 1'b1, 32'h7,    1'b1, 64'h0};
        v[10] = '{1'b0, 32'h0000, 1'b1, 1'b0, 32'h0,    1'b0, 64'h0};

        bus.ce = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h0;
        bus.flush = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 64'(bus.req_ready), 64'(0));
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("reset_rsp_inst", bus.rsp_inst, 64'h0);
        check("reset_rsp_addr", 64'(bus.rsp_addr), 64'h0);
        check("reset_rsp_fault", 64'(bus.rsp_fault), 64'(0));
        tick();
        rst = 1'b1;
        bus.rsp_ready = 1'b1;

        for (int i = 0; i < 11; i++) begin
            bus.req_valid = v[i].rv;
            bus.req_addr = v[i].addr;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), 64'(bus.req_ready), 64'(v[i].exp_rdy));
            check($sformatf("vec%0d_valid", i), 64'(bus.rsp_valid), 64'(v[i].exp_vld));
            if (v[i].exp_vld) begin
                check($sformatf("vec%0d_addr", i), 64'(bus.rsp_addr), 64'(v[i].exp_addr));
                check($sformatf("vec%0d_inst", i), bus.rsp_inst, v[i].exp_inst);
                check($sformatf("vec%0d_fault", i), 64'(bus.rsp_fault), 64'(v[i].exp_flt));
            end
            tick();
        end

        // Backpressure: only FIFO_DEPTH requests may be outstanding.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            bus.req_addr = addrs[n];
            @(negedge clk);
            acc = bus.req_ready;
            tick();
            if (acc) n++;
        end
        check("bp_accepted", 64'(n), 64'(4));
        bus.req_addr = addrs[n];
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_low_in_pop", 64'(bus.req_ready), 64'(0));
        check("bp_head_addr", 64'(bus.rsp_addr), 64'h0);
        check("bp_head_inst", bus.rsp_inst, M0);
        tick();
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_reraise", 64'(bus.req_ready), 64'(1));
        tick();
        bus.req_valid = 1'b0;
        expect_rsp("bp_r1", 32'h8, M1, 1'b0);
        expect_rsp("bp_r2", 32'h10, M2, 1'b0);
        expect_rsp("bp_r3", 32'h18, M3, 1'b0);
        expect_rsp("bp_r4", 32'h20, M4, 1'b0);

        // Flush with one in flight and two buffered, redirect to 0x40 in the same cycle.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h0;
        tick();
        bus.req_addr = 32'h8;
        tick();
        bus.req_addr = 32'h10;
        tick();
        bus.req_addr = 32'h40;
        bus.flush = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("fl_ready", 64'(bus.req_ready), 64'(1));
        check("fl_old_head_valid", 64'(bus.rsp_valid), 64'(1));
        check("fl_old_head_addr", 64'(bus.rsp_addr), 64'h0);
        tick();
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("fl_valid_after", 64'(bus.rsp_valid), 64'(0));
        tick();
        @(negedge clk);
        check("fl_target_valid", 64'(bus.rsp_valid), 64'(1));
        check("fl_target_addr", 64'(bus.rsp_addr), 64'h40);
        check("fl_target_inst", bus.rsp_inst, M8);
        tick();
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) extra++;
            tick();
        end
        check("fl_no_stale", 64'(extra), 64'(0));

        // ce low blocks acceptance but lets in-flight work drain.
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h8;
        tick();
        bus.req_addr = 32'h10;
        tick();
        bus.ce = 1'b0;
        bus.req_addr = 32'h18;
        @(negedge clk);
        check("ce_ready_low", 64'(bus.req_ready), 64'(0));
        check("ce_rsp1_valid", 64'(bus.rsp_valid), 64'(1));
        check("ce_rsp1_inst", bus.rsp_inst, M1);
        tick();
        @(negedge clk);
        check("ce_rsp2_addr", 64'(bus.rsp_addr), 64'h10);
        check("ce_rsp2_inst", bus.rsp_inst, M2);
        tick();
        @(negedge clk);
        check("ce_idle", 64'(bus.rsp_valid), 64'(0));
        tick();
        bus.ce = 1'b1;
        @(negedge clk);
        check("ce_resume_ready", 64'(bus.req_ready), 64'(1));
        tick();
        bus.req_valid = 1'b0;
        expect_rsp("ce_resume", 32'h18, M3, 1'b0);

        // Asynchronous reset with a non-empty FIFO.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h0;
        tick();
        bus.req_addr = 32'h8;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_pre_valid", 64'(bus.rsp_valid), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_async_ready", 64'(bus.req_ready), 64'(0));
        tick();
        tick();
        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("rst_post_ready", 64'(bus.req_ready), 64'(1));
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_post_lat1", 64'(bus.rsp_valid), 64'(0));
        tick();
        @(negedge clk);
        check("rst_post_valid", 64'(bus.rsp_valid), 64'(1));
        check("rst_post_addr", 64'(bus.rsp_addr), 64'h0);
        check("rst_post_inst", bus.rsp_inst, M0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
